// File: rtl/pwm_bank.sv
// pwm_bank: CHANNELS complementary PWM pairs sharing one prescaler and one
// period counter, with shadowed period/duty, dead time and a period irq.
// Ports: clk; rst (async, active-high); address/databi/databo/cen/wr bus
// (write on clk when cen && wr, databo combinational, 0 when !cen);
// q/n high/low-side outputs per channel; irq period interrupt.
module pwm_bank #(
    parameter int CHANNELS = 3,
    parameter int ADDR_W   = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   address,
    input  logic [7:0]          databi,
    output logic [7:0]          databo,
    input  logic                cen,
    input  logic                wr,
    output logic [CHANNELS-1:0] q,
    output logic [CHANNELS-1:0] n,
    output logic                irq
);

    localparam int A_CTRL   = 0;
    localparam int A_STATUS = 1;
    localparam int A_PRESC  = 2;
    localparam int A_PERIOD = 3;
    localparam int A_DEAD   = 4;
    localparam int A_DUTY   = 5;

    logic [3:0] ctrl;
    logic       en;
    logic       center;
    logic       invert;
    logic       irq_en;
    logic       pflag;
    logic       pending;
    logic [7:0] presc;
    logic [7:0] period_sh;
    logic [7:0] period_act;
    logic [7:0] deadtime;
    logic [7:0] duty_sh  [CHANNELS];
    logic [7:0] duty_act [CHANNELS];

    logic [7:0] pcnt;
    logic [7:0] cnt;
    logic       dir;
    logic       tick;
    logic       boundary;
    logic       en_rise;
    logic       load;

    logic                we;
    logic                sel_ctrl;
    logic                sel_status;
    logic                sel_presc;
    logic                sel_period;
    logic                sel_dead;
    logic [CHANNELS-1:0] sel_duty;
    logic                wr_shadow;

    logic [CHANNELS-1:0] raw;
    logic [CHANNELS-1:0] raw_prev;
    logic [CHANNELS-1:0] q_int;
    logic [CHANNELS-1:0] n_int;
    logic [7:0]          run_q   [CHANNELS];
    logic [7:0]          run_cur [CHANNELS];

    assign en     = ctrl[0];
    assign center = ctrl[1];
    assign invert = ctrl[2];
    assign irq_en = ctrl[3];
    assign we     = cen & wr;

    // ---------------- address decode ----------------
    always_comb begin
        sel_ctrl   = (address == ADDR_W'(A_CTRL));
        sel_status = (address == ADDR_W'(A_STATUS));
        sel_presc  = (address == ADDR_W'(A_PRESC));
        sel_period = (address == ADDR_W'(A_PERIOD));
        sel_dead   = (address == ADDR_W'(A_DEAD));
        sel_duty   = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            sel_duty[k] = (address == ADDR_W'(A_DUTY + k));
        end
    end

    assign wr_shadow = we & (sel_period | (|sel_duty));
    assign en_rise   = we & sel_ctrl & databi[0] & ~en;

    // ---------------- read mux ----------------
    always_comb begin
        databo = 8'h00;
        if (cen) begin
            unique case (1'b1)
                sel_ctrl:   databo = {4'h0, ctrl};
                sel_status: databo = {6'h00, pending, pflag};
                sel_presc:  databo = presc;
                sel_period: databo = period_sh;
                sel_dead:   databo = deadtime;
                default: begin
                    for (int k = 0; k < CHANNELS; k++) begin
                        if (sel_duty[k]) databo = duty_sh[k];
                    end
                end
            endcase
        end
    end

    // ---------------- timebase ----------------
    assign tick = en & (pcnt == presc);

    // Center mode holds each endpoint for two ticks: the turn happens
    // on a tick without moving cnt, only flipping dir.
    always_comb begin
        boundary = 1'b0;
        if (tick) begin
            if (!center) begin
                boundary = (cnt >= period_act);
            end else if (period_act == 8'd0) begin
                boundary = 1'b1;
            end else begin
                boundary = dir & (cnt == 8'd0);
            end
        end
    end

    assign load = boundary | en_rise;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt <= 8'd0;
            cnt  <= 8'd0;
            dir  <= 1'b0;
        end else if (!en) begin
            pcnt <= 8'd0;
            cnt  <= 8'd0;
            dir  <= 1'b0;
        end else if (tick) begin
            pcnt <= 8'd0;
            if (!center) begin
                dir <= 1'b0;
                cnt <= boundary ? 8'd0 : cnt + 8'd1;
            end else if (period_act == 8'd0) begin
                dir <= 1'b0;
                cnt <= 8'd0;
            end else if (!dir) begin
                if (cnt >= period_act - 8'd1) begin
                    dir <= 1'b1;
                end else begin
                    cnt <= cnt + 8'd1;
                end
            end else begin
                if (cnt == 8'd0) begin
                    dir <= 1'b0;
                end else begin
                    cnt <= cnt - 8'd1;
                end
            end
        end else begin
            pcnt <= pcnt + 8'd1;
        end
    end

    // ---------------- registers ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl       <= 4'h0;
            presc      <= 8'h00;
            period_sh  <= 8'hFF;
            period_act <= 8'hFF;
            deadtime   <= 8'h00;
            pflag      <= 1'b0;
            pending    <= 1'b0;
        end else begin
            if (we && sel_ctrl)   ctrl      <= databi[3:0];
            if (we && sel_presc)  presc     <= databi;
            if (we && sel_period) period_sh <= databi;
            if (we && sel_dead)   deadtime  <= databi;
            // load samples the pre-write shadow when both coincide
            if (load) period_act <= period_sh;
            if (boundary) begin
                pflag <= 1'b1;
            end else if (we && sel_status && databi[0]) begin
                pflag <= 1'b0;
            end
            if (wr_shadow) begin
                pending <= 1'b1;
            end else if (load) begin
                pending <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < CHANNELS; k++) begin
                duty_sh[k]  <= 8'h00;
                duty_act[k] <= 8'h00;
            end
        end else begin
            for (int k = 0; k < CHANNELS; k++) begin
                if (we && sel_duty[k]) duty_sh[k]  <= databi;
                if (load)              duty_act[k] <= duty_sh[k];
            end
        end
    end

    // ---------------- compare and dead time ----------------
    // run_cur: cycles raw has already held its present value before
    // this one; an edge on raw restarts it at 0.
    always_comb begin
        raw   = '0;
        q_int = '0;
        n_int = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            raw[k]     = (cnt < duty_act[k]);
            run_cur[k] = (raw[k] == raw_prev[k]) ? run_q[k] : 8'd0;
            q_int[k]   = raw[k] & (run_cur[k] >= deadtime);
            n_int[k]   = ~raw[k] & (run_cur[k] >= deadtime);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            raw_prev <= '0;
            q        <= '0;
            n        <= '0;
            irq      <= 1'b0;
            for (int k = 0; k < CHANNELS; k++) begin
                run_q[k] <= 8'd0;
            end
        end else begin
            irq <= pflag & irq_en;
            if (!en) begin
                raw_prev <= '0;
                q        <= '0;
                n        <= '0;
                for (int k = 0; k < CHANNELS; k++) begin
                    run_q[k] <= 8'd0;
                end
            end else begin
                raw_prev <= raw;
                q        <= q_int ^ {CHANNELS{invert}};
                n        <= n_int ^ {CHANNELS{invert}};
                for (int k = 0; k < CHANNELS; k++) begin
                    run_q[k] <= (run_cur[k] == 8'hFF) ? 8'hFF
                                                      : run_cur[k] + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pwm_bank.sv
// tb_pwm_bank: random and directed stimulus for pwm_bank, checked
// cycle by cycle against a period-position reference model.
module tb_pwm_bank;

    localparam int CH = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    address;
    logic [7:0]    databi;
    logic [7:0]    databo;
    logic          cen;
    logic          wr;
    logic [CH-1:0] q;
    logic [CH-1:0] n;
    logic          irq;

    always #5 clk = ~clk;

    pwm_bank #(.CHANNELS(CH), .ADDR_W(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .address (address),
        .databi  (databi),
        .databo  (databo),
        .cen     (cen),
        .wr      (wr),
        .q       (q),
        .n       (n),
        .irq     (irq)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [3:0]    m_ctrl;
    logic          m_pflag;
    logic          m_pending;
    logic [7:0]    m_presc;
    logic [7:0]    m_per_sh;
    logic [7:0]    m_per_act;
    logic [7:0]    m_dt;
    logic [7:0]    m_duty_sh  [CH];
    logic [7:0]    m_duty_act [CH];
    int            m_pre;
    int            m_pos;
    bit            m_hist [CH][$];
    logic [CH-1:0] m_q;
    logic [CH-1:0] m_n;
    logic          m_irq;

    task automatic m_reset();
        m_ctrl    = 4'h0;
        m_pflag   = 1'b0;
        m_pending = 1'b0;
        m_presc   = 8'h00;
        m_per_sh  = 8'hFF;
        m_per_act = 8'hFF;
        m_dt      = 8'h00;
        for (int k = 0; k < CH; k++) begin
            m_duty_sh[k]  = 8'h00;
            m_duty_act[k] = 8'h00;
            m_hist[k].delete();
        end
        m_pre = 0;
        m_pos = 0;
        m_q   = '0;
        m_n   = '0;
        m_irq = 1'b0;
    endtask

    // Counter value as a function of position inside the period.
    function automatic int m_cnt(input bit ctr, input int p, input int pos);
        if (!ctr) return pos;
        if (p == 0) return 0;
        return (pos < p) ? pos : 2 * p - 1 - pos;
    endfunction

    function automatic int m_len(input bit ctr, input int p);
        if (!ctr) return p + 1;
        return (p == 0) ? 1 : 2 * p;
    endfunction

    task automatic m_step(input bit we, input logic [3:0] a,
                          input logic [7:0] d);
        bit            en;
        bit            ctr;
        bit            inv;
        bit            tk;
        bit            bnd;
        bit            load;
        bit            raw;
        bit            ok;
        int            p;
        int            c;
        int            sz;
        int            dt;
        logic [CH-1:0] qn;
        logic [CH-1:0] nn;
        en  = m_ctrl[0];
        ctr = m_ctrl[1];
        inv = m_ctrl[2];
        p   = int'(m_per_act);
        dt  = int'(m_dt);
        c   = m_cnt(ctr, p, m_pos);
        tk  = en && (m_pre == int'(m_presc));
        bnd = tk && (m_pos == m_len(ctr, p) - 1);
        qn  = '0;
        nn  = '0;
        for (int k = 0; k < CH; k++) begin
            raw = (c < int'(m_duty_act[k]));
            if (!en) begin
                m_hist[k].delete();
            end else begin
                m_hist[k].push_back(raw);
                if (m_hist[k].size() > 16) void'(m_hist[k].pop_front());
                sz = m_hist[k].size();
                ok = (sz >= dt + 1);
                for (int i = 0; i <= dt && ok; i++) begin
                    if (m_hist[k][sz - 1 - i] != raw) ok = 1'b0;
                end
                qn[k] = (raw && ok) ^ inv;
                nn[k] = (!raw && ok) ^ inv;
            end
        end
        m_q   = qn;
        m_n   = nn;
        m_irq = m_pflag && m_ctrl[3];
        load  = bnd || (we && a == 4'd0 && d[0] && !en);
        if (!en) begin
            m_pre = 0;
            m_pos = 0;
        end else if (tk) begin
            m_pre = 0;
            m_pos = bnd ? 0 : m_pos + 1;
        end else begin
            m_pre++;
        end
        if (bnd) m_pflag = 1'b1;
        else if (we && a == 4'd1 && d[0]) m_pflag = 1'b0;
        if (we && (a == 4'd3 || (a >= 4'd5 && int'(a) < 5 + CH)))
            m_pending = 1'b1;
        else if (load)
            m_pending = 1'b0;
        if (load) begin
            m_per_act = m_per_sh;
            for (int k = 0; k < CH; k++) m_duty_act[k] = m_duty_sh[k];
        end
        if (we) begin
            case (a)
                4'd0: m_ctrl   = d[3:0];
                4'd2: m_presc  = d;
                4'd3: m_per_sh = d;
                4'd4: m_dt     = d;
                default: begin
                    if (a >= 4'd5 && int'(a) < 5 + CH)
                        m_duty_sh[int'(a) - 5] = d;
                end
            endcase
        end
    endtask

    function automatic logic [7:0] m_read(input logic c, input logic [3:0] a);
        if (!c) return 8'h00;
        case (a)
            4'd0: return {4'h0, m_ctrl};
            4'd1: return {6'h00, m_pending, m_pflag};
            4'd2: return m_presc;
            4'd3: return m_per_sh;
            4'd4: return m_dt;
            default: begin
                if (a >= 4'd5 && int'(a) < 5 + CH)
                    return m_duty_sh[int'(a) - 5];
                return 8'h00;
            end
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) m_reset();
        else m_step(cen && wr, address, databi);
    end

    // ---------------- drivers ----------------
    int hi_q [CH];
    int hi_n [CH];
    int both0;

    task automatic clr_cnt();
        for (int k = 0; k < CH; k++) begin
            hi_q[k] = 0;
            hi_n[k] = 0;
        end
        both0 = 0;
    endtask

    task automatic cyc(input logic c, input logic w, input logic [3:0] a,
                       input logic [7:0] d);
        @(negedge clk);
        chk("q", q, m_q);
        chk("n", n, m_n);
        chk("irq", irq, m_irq);
        for (int k = 0; k < CH; k++) begin
            hi_q[k] += int'(q[k]);
            hi_n[k] += int'(n[k]);
        end
        both0 += int'(q[0] & n[0]);
        cen     = c;
        wr      = w;
        address = a;
        databi  = d;
        #1;
        chk("databo", databo, m_read(c, a));
    endtask

    task automatic wr_reg(input logic [3:0] a, input logic [7:0] d);
        cyc(1'b1, 1'b1, a, d);
    endtask

    task automatic idle(input int nc);
        repeat (nc) begin
            cyc(1'($urandom_range(0, 1)), 1'b0,
                4'($urandom_range(0, 15)), 8'($urandom));
        end
    endtask

    task automatic rd(input logic [3:0] a);
        cyc(1'b1, 1'b0, a, 8'h00);
    endtask

    task automatic wait_irq(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            cyc(1'b0, 1'b0, 4'd0, 8'h00);
            if (irq) seen = 1'b1;
        end
    endtask

    // ---------------- test sequence ----------------
    initial begin
        bit         seen;
        logic [3:0] c4;
        bit         cm;
        m_reset();
        clr_cnt();
        rst     = 1'b1;
        cen     = 1'b0;
        wr      = 1'b0;
        address = 4'd0;
        databi  = 8'h00;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // reset values
        rd(4'd3); chk("rst_period", databo, 8'hFF);
        rd(4'd5); chk("rst_duty0", databo, 8'h00);
        rd(4'd0); chk("rst_ctrl", databo, 8'h00);
        rd(4'd1); chk("rst_status", databo, 8'h00);
        chk("rst_q", q, 0);

        // edge mode
        wr_reg(4'd2, 8'd0);
        wr_reg(4'd3, 8'd9);
        wr_reg(4'd5, 8'd3);
        wr_reg(4'd6, 8'd0);
        wr_reg(4'd7, 8'd10);
        wr_reg(4'd4, 8'd0);
        rd(4'd1); chk("pend_dis", databo, 8'h02);
        wr_reg(4'd0, 8'h01);
        idle(30);
        clr_cnt();
        idle(20);
        chk("edge_q0", hi_q[0], 6);
        chk("edge_n0", hi_n[0], 14);
        chk("edge_q1", hi_q[1], 0);
        chk("edge_q2", hi_q[2], 20);

        // dead time
        wr_reg(4'd4, 8'd2);
        idle(30);
        clr_cnt();
        idle(20);
        chk("dt_q0", hi_q[0], 2);
        chk("dt_n0", hi_n[0], 10);
        chk("dt_both", both0, 0);
        chk("dt_n1", hi_n[1], 20);
        chk("dt_q2", hi_q[2], 20);

        // center mode
        wr_reg(4'd0, 8'h00);
        wr_reg(4'd3, 8'd4);
        wr_reg(4'd5, 8'd1);
        wr_reg(4'd4, 8'd0);
        wr_reg(4'd0, 8'h03);
        idle(20);
        clr_cnt();
        idle(16);
        chk("ctr_q0", hi_q[0], 4);
        chk("ctr_n0", hi_n[0], 12);
        chk("ctr_q2", hi_q[2], 16);

        // shadow update
        wr_reg(4'd0, 8'h00);
        wr_reg(4'd3, 8'd9);
        wr_reg(4'd5, 8'd3);
        wr_reg(4'd1, 8'h01);
        wr_reg(4'd0, 8'h01);
        idle(4);
        wr_reg(4'd5, 8'd6);
        rd(4'd1); chk("shadow_pend", databo, 8'h02);
        rd(4'd5); chk("shadow_rd", databo, 8'd6);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            rd(4'd1);
            if (databo[1] == 1'b0) seen = 1'b1;
        end
        chk("shadow_clr", seen, 1);
        clr_cnt();
        idle(20);
        chk("shadow_q0", hi_q[0], 12);

        // prescaler and irq
        wr_reg(4'd0, 8'h00);
        wr_reg(4'd2, 8'd3);
        wr_reg(4'd3, 8'd9);
        wr_reg(4'd5, 8'd3);
        wr_reg(4'd1, 8'h01);
        wr_reg(4'd0, 8'h09);
        chk("irq_low", irq, 0);
        wait_irq(seen);
        chk("irq_rise", seen, 1);
        wr_reg(4'd1, 8'h01);
        idle(2);
        chk("irq_clr", irq, 0);
        wait_irq(seen);
        chk("irq_rise2", seen, 1);
        repeat (37) cyc(1'b0, 1'b0, 4'd0, 8'h00);
        wr_reg(4'd1, 8'h01);
        idle(3);
        chk("irq_setwins", irq, 1);
        rd(4'd1); chk("pflag_setwins", databo[0], 1);
        clr_cnt();
        idle(80);
        chk("presc_q0", hi_q[0], 24);

        // asynchronous reset while q0 is high
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            cyc(1'b0, 1'b0, 4'd0, 8'h00);
            if (q[0]) seen = 1'b1;
        end
        chk("q0_high", seen, 1);
        rst = 1'b1;
        #1;
        chk("arst_q", q, 0);
        chk("arst_n", n, 0);
        chk("arst_irq", irq, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        rd(4'd3); chk("arst_period", databo, 8'hFF);
        rd(4'd5); chk("arst_duty0", databo, 8'h00);
        rd(4'd0); chk("arst_ctrl", databo, 8'h00);

        // randomized phases
        for (int ph = 0; ph < 12; ph++) begin
            wr_reg(4'd0, 8'h00);
            wr_reg(4'd2, 8'($urandom_range(0, 3)));
            wr_reg(4'd3, 8'($urandom_range(0, 12)));
            wr_reg(4'd4, 8'($urandom_range(0, 5)));
            for (int k = 0; k < CH; k++)
                wr_reg(4'(5 + k), 8'($urandom_range(0, 14)));
            wr_reg(4'd1, 8'h01);
            cm    = 1'($urandom_range(0, 1));
            c4[0] = 1'b1;
            c4[1] = cm;
            c4[2] = 1'($urandom_range(0, 1));
            c4[3] = 1'($urandom_range(0, 1));
            wr_reg(4'd0, {4'h0, c4});
            for (int i = 0; i < 150; i++) begin
                if ($urandom_range(0, 99) < 85) begin
                    idle(1);
                end else begin
                    case ($urandom_range(0, 6))
                        0: wr_reg(4'd1, 8'($urandom));
                        1: wr_reg(4'd3, 8'($urandom_range(0, 12)));
                        2: wr_reg(4'd4, 8'($urandom_range(0, 5)));
                        3, 4: wr_reg(4'(5 + $urandom_range(0, CH - 1)),
                                     8'($urandom_range(0, 14)));
                        5: begin
                            c4[0] = ($urandom_range(0, 4) != 0);
                            c4[1] = cm;
                            c4[2] = 1'($urandom_range(0, 1));
                            c4[3] = 1'($urandom_range(0, 1));
                            wr_reg(4'd0, {4'($urandom), c4} & 8'h0F
                                         | {4'($urandom), 4'h0});
                        end
                        default: wr_reg(4'($urandom_range(8, 15)),
                                        8'($urandom));
                    endcase
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pwm_bank.md
Name: pwm_bank

Overview:
- Multi-channel successor to the single-channel pwm peripheral on the 8-bit MinxTop I/O bus. Drives CHANNELS complementary output pairs from one shared prescaler and period counter.
- Per-channel duty registers are shadowed, so updates are glitch-free.
- Adds programmable dead time, edge- or center-aligned counting, output polarity and a period interrupt.
- Sits in the user_ioce address window; the top-level I/O mux selects databo.

Parameters:
- CHANNELS, 3, number of output pairs; legal range 1..11.
- ADDR_W, 4, register address width.

Ports:
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-high
- address  input  ADDR_W  register index
- databi  input  8  write data
- databo  output  8  read data
- cen  input  1  block select
- wr  input  1  write strobe; a write occurs on the clk edge when cen && wr
- q  output  CHANNELS  high-side outputs
- n  output  CHANNELS  low-side (complementary) outputs
- irq  output  1  period interrupt

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high.
- Reset values: CTRL=0, STATUS=0, PRESC=0, PERIOD shadow and active=0xFF, DEADTIME=0, every DUTY shadow and active=0, counters=0, q=0, n=0, irq=0.
- Register map:
  - 0x0 CTRL: [0] en, [1] center, [2] invert, [3] irq_en.
  - 0x1 STATUS: [0] pflag (sticky; writing 1 clears it), [1] pending (read-only).
  - 0x2 PRESC.
  - 0x3 PERIOD.
  - 0x4 DEADTIME.
  - 0x5+k DUTY[k], for k<CHANNELS.
  - Unmapped addresses read 0x00; writes to them are ignored.
- Reads: databo is combinational. databo = selected register when cen=1, else 0x00. PERIOD and DUTY read back their shadow values.
- Prescaler: 8-bit counter runs 0..PRESC. It emits tick when it equals PRESC, then returns to 0. One tick every PRESC+1 clk.
- Edge mode (center=0):
  - Counter runs 0..PERIOD, then wraps to 0. Period is PERIOD+1 ticks.
  - Boundary = the wrap.
- Center mode (center=1):
  - Counter runs up 0..PERIOD-1, then down PERIOD-1..0, holding each endpoint for two ticks. Period is 2*PERIOD ticks.
  - Boundary = down phase reaches 0 and turns up.
  - PERIOD=0: counter held at 0; boundary every tick.
- Raw compare per channel: raw[k] = (cnt < duty_active[k]).
  - duty=0 gives constant low.
  - duty>PERIOD (edge) or duty>=PERIOD (center) gives constant high.
- Shadowing:
  - Writes to PERIOD or DUTY update the shadow and set pending.
  - At a boundary, all active registers load from the shadows and pending clears.
  - Write in the same cycle as a boundary: the boundary loads the pre-write shadow, and pending remains set.
  - PRESC, DEADTIME and CTRL take effect immediately.
- Enable:
  - en 0→1: active registers load from the shadows, counters restart at 0, pending clears.
  - en=0: counters held at 0; q=n=0 regardless of invert; pflag is not set.
- Dead time (per channel, counted in clk cycles):
  - q_int rises only after raw has been continuously 1 for DEADTIME cycles.
  - n_int rises only after raw has been continuously 0 for DEADTIME cycles.
  - Both fall in the cycle raw changes.
  - DEADTIME=0: q_int=raw, n_int=~raw.
  - q_int and n_int are never both 1.
  - If a raw pulse is shorter than DEADTIME, the corresponding output stays low.
- Outputs: q/n are registered, 1 clk after raw changes (when DEADTIME=0). When enabled, q = q_int^invert and n = n_int^invert.
- Interrupt:
  - pflag is set on every boundary while en=1.
  - irq = pflag & irq_en, registered.
  - Boundary in the same cycle as a write-1-clear: set wins.
- Reset mid-operation clears everything immediately, without waiting for clk; outputs go low asynchronously.

Test Plan:
- Reset: assert rst mid-PWM with q0=1 → q=n=0 and irq=0 immediately; after release, reads give PERIOD=0xFF, DUTY0=0x00, CTRL=0x00.
- Edge mode: PRESC=0, PERIOD=9, DUTY0=3, DEADTIME=0, CTRL=0x01 → q0 high 3 clk / low 7 clk, repeating every 10 clk; n0 is the exact complement; DUTY1=0 gives q1 constant 0, DUTY2=10 gives q2 constant 1.
- Dead time: same setup with DEADTIME=2 → q0 high 1 clk, n0 high 5 clk per 10-clk period, with 2-clk gaps where both are low; q0&n0 never 1.
- Center mode: CTRL=0x03, PERIOD=4, DUTY0=1 → period 8 clk; q0 high 2 consecutive clk, centered on the counter-0 turnaround.
- Shadow update: while running DUTY0=3, write DUTY0=6 mid-period → current period keeps 3-clk high; STATUS=0x02 until the boundary; next period is 6 high / 4 low.
- Prescaler and irq: PRESC=3, PERIOD=9, CTRL=0x09 → period 40 clk; irq rises 1 clk after the boundary; writing STATUS=0x01 clears it; a clear coinciding with a boundary leaves irq=1.
